// File: rtl/cct_seq_pkg.sv
// cct_seq_pkg: shared types and constants for the cct_sequencer block.
//   state_e   : sequencer FSM states (IDLE, CLEAR, RUN, DONE)
//   CCT_W     : width of the student circuit datapath
//   TXN_CNT_W : width of the optional transaction counter
package cct_seq_pkg;

  localparam int CCT_W     = 8;
  localparam int TXN_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cct_sequencer_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered search pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   advance    : accept the current winner and move the pointer past it
//   gnt        : one-hot winner (combinational from req and pointer)
//   ptr        : index where the next search starts (0 after reset)
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] idx;
  logic          found;

  // Scan from ptr_q upward with wrap; the first pending index wins.
  always_comb begin
    gnt     = '0;
    win_idx = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = PW'((int'(ptr_q) + off) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        win_idx  = idx;
        found    = 1'b1;
      end
    end
    // Explicit wrap so non-power-of-two NREQ stays in range.
    ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/cct_sequencer.sv
// cct_sequencer: shares one student circuit among NREQ requesters.
// Grants round-robin, clears the circuit, applies the winner's operand
// for RUN_CYCLES clocks, captures cct_output and pulses done.
//   clk, clear_n : clock, asynchronous active-low reset
//   req/req_data : per-requester request level and 8-bit operand
//   grant/done   : one-hot grant (whole transaction), one-cycle done pulse
//   result       : captured circuit output, held until next capture
//   busy         : high outside IDLE
//   cct_clear/cct_input/cct_output : student circuit connection
//   state_dbg    : current FSM state encoding
// Optional build macro CCT_SEQ_STATS_EN adds txn_count and last_winner.
//
// Handshake: a requester holds req high until it sees its grant bit; req is
// sampled only in IDLE. Once granted, req and req_data are ignored until
// done pulses for one cycle alongside the still-high grant; the requester
// must not re-request before that done pulse.
module cct_sequencer
  import cct_seq_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int RUN_CYCLES = 8,
  localparam int IW         = $clog2(NREQ),
  localparam int CW         = $clog2(RUN_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CCT_W-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [CCT_W-1:0]      result,
  output logic                  busy,
  output logic                  cct_clear,
  output logic [CCT_W-1:0]      cct_input,
  input  logic [CCT_W-1:0]      cct_output,
  output logic [1:0]            state_dbg
`ifdef CCT_SEQ_STATS_EN
  ,
  output logic [TXN_CNT_W-1:0]  txn_count,
  output logic [IW-1:0]         last_winner
`endif
);

  state_e          state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic [CCT_W-1:0] result_q;
  logic [CCT_W-1:0] op_q;
  logic [CCT_W-1:0] cct_input_q;
  logic            cct_clear_q;
  logic            busy_q;
  logic [CW-1:0]   run_cnt_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_ptr;
  logic            advance;
  logic [IW-1:0]   win_idx;
  logic [CCT_W-1:0] win_data;

  assign advance = (state_q == IDLE) && (|req);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (clear_n),
    .req     (req),
    .advance (advance),
    .gnt     (arb_gnt),
    .ptr     (arb_ptr)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) win_idx = IW'(i);
    end
    win_data = req_data[CCT_W*win_idx +: CCT_W];
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      result_q    <= '0;
      op_q        <= '0;
      cct_input_q <= '0;
      cct_clear_q <= 1'b1;
      busy_q      <= 1'b0;
      run_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q     <= CLEAR;
            grant_q     <= arb_gnt;
            op_q        <= win_data;
            cct_input_q <= win_data;
            busy_q      <= 1'b1;
          end
        end
        CLEAR: begin
          state_q     <= RUN;
          cct_clear_q <= 1'b0;
          run_cnt_q   <= '0;
        end
        RUN: begin
          run_cnt_q <= run_cnt_q + CW'(1);
          if (run_cnt_q == CW'(RUN_CYCLES - 1)) begin
            state_q     <= DONE;
            result_q    <= cct_output;
            done_q      <= grant_q;
            cct_clear_q <= 1'b1;
            cct_input_q <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          grant_q <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign cct_clear = cct_clear_q;
  assign cct_input = cct_input_q;
  assign state_dbg = state_q;

`ifdef CCT_SEQ_STATS_EN
  logic [TXN_CNT_W-1:0] txn_q;
  logic [IW-1:0]        last_win_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      txn_q      <= '0;
      last_win_q <= '0;
    end else begin
      if (state_q == DONE) txn_q <= txn_q + TXN_CNT_W'(1);
      if (advance)         last_win_q <= win_idx;
    end
  end

  assign txn_count   = txn_q;
  assign last_winner = last_win_q;
`endif

endmodule
